// File: rtl/taus_pkg.sv
// Shared constants, types and step/seed helpers for the multi-channel taus88 uniform generator.
package taus_pkg;

  localparam logic [31:0] TAUS_GOLDEN = 32'h9E37_79B9;

  localparam logic [31:0] MIN_S0 = 32'd2;
  localparam logic [31:0] MIN_S1 = 32'd8;
  localparam logic [31:0] MIN_S2 = 32'd16;

  localparam logic [31:0] MASK_S0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK_S1 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK_S2 = 32'hFFFF_FFF0;

  localparam int unsigned S0_SHL = 32'd13;
  localparam int unsigned S0_SHR = 32'd19;
  localparam int unsigned S0_SHM = 32'd12;
  localparam int unsigned S1_SHL = 32'd2;
  localparam int unsigned S1_SHR = 32'd25;
  localparam int unsigned S1_SHM = 32'd4;
  localparam int unsigned S2_SHL = 32'd3;
  localparam int unsigned S2_SHR = 32'd11;
  localparam int unsigned S2_SHM = 32'd17;

  typedef enum logic [1:0] {
    SEL_S0 = 2'd0,
    SEL_S1 = 2'd1,
    SEL_S2 = 2'd2
  } seed_sel_e;

  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } taus_state_t;

  // All arithmetic stays 32 bits wide so bits shifted past the MSB are dropped.
  function automatic taus_state_t taus_step(input taus_state_t s);
    taus_state_t n;
    logic [31:0] b;
    b    = ((s.s0 << S0_SHL) ^ s.s0) >> S0_SHR;
    n.s0 = ((s.s0 & MASK_S0) << S0_SHM) ^ b;
    b    = ((s.s1 << S1_SHL) ^ s.s1) >> S1_SHR;
    n.s1 = ((s.s1 & MASK_S1) << S1_SHM) ^ b;
    b    = ((s.s2 << S2_SHL) ^ s.s2) >> S2_SHR;
    n.s2 = ((s.s2 & MASK_S2) << S2_SHM) ^ b;
    return n;
  endfunction

  function automatic logic [31:0] taus_out(input taus_state_t s);
    return s.s0 ^ s.s1 ^ s.s2;
  endfunction

  // A component seeded below its minimum collapses to a short cycle, so it is refused.
  function automatic logic seed_valid(input logic [1:0] sel, input logic [31:0] data);
    logic ok;
    case (seed_sel_e'(sel))
      SEL_S0:  ok = (data >= MIN_S0);
      SEL_S1:  ok = (data >= MIN_S1);
      SEL_S2:  ok = (data >= MIN_S2);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic taus_state_t taus_seed(input logic [31:0] mix, input logic [31:0] seed0,
                                            input logic [31:0] seed1, input logic [31:0] seed2);
    taus_state_t s;
    s.s0 = (seed0 ^ mix) | 32'h0000_0002;
    s.s1 = (seed1 ^ mix) | 32'h0000_0008;
    s.s2 = (seed2 ^ mix) | 32'h0000_0010;
    return s;
  endfunction

endpackage

// File: rtl/taus_core.sv
// One taus88 channel: state registers, next-state logic and the per-word seed write port.
module taus_core
  import taus_pkg::*;
#(
  parameter int unsigned CH    = 0,
  parameter logic [31:0] SEED0 = 32'h0000_1234,
  parameter logic [31:0] SEED1 = 32'h0000_5678,
  parameter logic [31:0] SEED2 = 32'h0009_ABCD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic [31:0] tout
);

  localparam logic [31:0] MIX = 32'(CH) * TAUS_GOLDEN;
  localparam taus_state_t INIT = taus_seed(MIX, SEED0, SEED1, SEED2);

  taus_state_t state_r;
  taus_state_t next_s;

  // Next state and its output word, consumed by the top only when it advances.
  always_comb begin
    next_s = taus_step(state_r);
  end

  assign tout = taus_out(next_s);

  // A seed write overwrites one word and wins over stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= INIT;
    end else if (wr_en) begin
      case (seed_sel_e'(wr_sel))
        SEL_S0:  state_r.s0 <= wr_data;
        SEL_S1:  state_r.s1 <= wr_data;
        SEL_S2:  state_r.s2 <= wr_data;
        default: state_r    <= state_r;
      endcase
    end else if (adv) begin
      state_r <= next_s;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/taus_urng_mc.sv
// Multi-channel taus88 uniform generator with seed loading and a valid/ready output stream.
module taus_urng_mc
  import taus_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned OUT_W  = 32,
  parameter logic [31:0] SEED0  = 32'h0000_1234,
  parameter logic [31:0] SEED1  = 32'h0000_5678,
  parameter logic [31:0] SEED2  = 32'h0009_ABCD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     seed_we,
  input  logic [2:0]               seed_ch,
  input  logic [1:0]               seed_sel,
  input  logic [31:0]              seed_data,
  output logic                     seed_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*OUT_W-1:0]  out_data
);

  logic                    adv_s;
  logic                    ch_ok_s;
  logic                    seed_ok_s;
  logic [31:0]             tout_s [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] data_next_s;
  logic [NUM_CH*OUT_W-1:0] out_data_r;
  logic                    out_valid_r;
  logic                    seed_err_r;

  assign ch_ok_s   = ({1'b0, seed_ch} < 4'(NUM_CH));
  assign seed_ok_s = ch_ok_s & seed_valid(seed_sel, seed_data);
  // A seed write blocks stepping so the next beat comes from the freshly written state.
  assign adv_s     = en & ~seed_we & (~out_valid_r | out_ready);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_en_s;
    assign wr_en_s = seed_we & seed_ok_s & (seed_ch == 3'(c));

    taus_core #(
      .CH    (c),
      .SEED0 (SEED0),
      .SEED1 (SEED1),
      .SEED2 (SEED2)
    ) u_core (
      .clk     (clk),
      .reset   (reset),
      .adv     (adv_s),
      .wr_en   (wr_en_s),
      .wr_sel  (seed_sel),
      .wr_data (seed_data),
      .tout    (tout_s[c])
    );
  end

  // Pack the top OUT_W bits of each channel into its lane.
  always_comb begin
    data_next_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      data_next_s[c*OUT_W +: OUT_W] = tout_s[c][31 -: OUT_W];
    end
  end

  // Output register, handshake and seed error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      seed_err_r  <= 1'b0;
    end else begin
      seed_err_r <= seed_we & ~seed_ok_s;
      if (seed_we) begin
        out_valid_r <= 1'b0;
      end else if (adv_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= data_next_s;
      end else if (out_valid_r & out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign seed_err  = seed_err_r;

endmodule

// File: tb/tb_taus_urng_mc.sv
// Self-checking bench: transferred beats are compared against a transaction-level taus88 model.
module tb_taus_urng_mc;

  localparam int NUM_CH = 2;
  localparam int OUT_W  = 32;
  localparam int DW     = NUM_CH * OUT_W;
  localparam logic [31:0] SEED0 = 32'h0000_1234;
  localparam logic [31:0] SEED1 = 32'h0000_5678;
  localparam logic [31:0] SEED2 = 32'h0009_ABCD;
  localparam logic [31:0] GOLD  = 32'h9E37_79B9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          seed_we = 1'b0;
  logic [2:0]    seed_ch = 3'd0;
  logic [1:0]    seed_sel = 2'd0;
  logic [31:0]   seed_data = 32'd0;
  logic          out_ready = 1'b0;
  logic          seed_err;
  logic          out_valid;
  logic [DW-1:0] out_data;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: the generator state after the last beat that was consumed or flushed.
  logic [31:0]   m_s [NUM_CH][3];
  logic [DW-1:0] first_run [6];

  always #5 clk = ~clk;

  taus_urng_mc #(
    .NUM_CH (NUM_CH),
    .OUT_W  (OUT_W),
    .SEED0  (SEED0),
    .SEED1  (SEED1),
    .SEED2  (SEED2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seed_we   (seed_we),
    .seed_ch   (seed_ch),
    .seed_sel  (seed_sel),
    .seed_data (seed_data),
    .seed_err  (seed_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [31:0] ref_s0(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & ~32'd1) << 12) ^ b;
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & ~32'd7) << 4) ^ b;
  endfunction

  function automatic logic [31:0] ref_s2(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & ~32'd15) << 17) ^ b;
  endfunction

  function automatic void model_reset();
    logic [31:0] mix;
    for (int c = 0; c < NUM_CH; c++) begin
      mix = 32'(c) * GOLD;
      m_s[c][0] = (SEED0 ^ mix) | 32'h2;
      m_s[c][1] = (SEED1 ^ mix) | 32'h8;
      m_s[c][2] = (SEED2 ^ mix) | 32'h10;
    end
  endfunction

  function automatic logic [DW-1:0] peek_beat();
    logic [DW-1:0] r;
    logic [31:0]   t;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      t = ref_s0(m_s[c][0]) ^ ref_s1(m_s[c][1]) ^ ref_s2(m_s[c][2]);
      r[c*OUT_W +: OUT_W] = t[31 -: OUT_W];
    end
    return r;
  endfunction

  function automatic void commit_beat();
    for (int c = 0; c < NUM_CH; c++) begin
      m_s[c][0] = ref_s0(m_s[c][0]);
      m_s[c][1] = ref_s1(m_s[c][1]);
      m_s[c][2] = ref_s2(m_s[c][2]);
    end
  endfunction

  function automatic bit seed_ok(input int ch, input int sel, input logic [31:0] d);
    if (ch >= NUM_CH || sel > 2) return 1'b0;
    if (sel == 0) return d >= 32'd2;
    if (sel == 1) return d >= 32'd8;
    return d >= 32'd16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one seed write; any outstanding beat leaves the stream (consumed or flushed).
  task automatic seed_write(input int ch, input int sel, input logic [31:0] d, output bit exp_err);
    seed_we   = 1'b1;
    seed_ch   = 3'(ch);
    seed_sel  = 2'(sel);
    seed_data = d;
    if (out_valid) commit_beat();
    tick();
    seed_we = 1'b0;
    exp_err = !seed_ok(ch, sel, d);
    if (!exp_err) m_s[ch][sel] = d;
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp;
    reset = 1'b0; en = 1'b1; out_ready = 1'b1;
    model_reset();
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (seed_err !== 1'b0) $display("FAIL reset_err: got %b want 0", seed_err); else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = peek_beat();
      first_run[i] = exp;
      n_total++; if (out_valid !== 1'b1) $display("FAIL first_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_total++; if (out_data !== exp) $display("FAIL first_data[%0d]: got %h want %h", i, out_data, exp); else n_pass++;
      if (i == 0) begin
        n_total++;
        if (out_data[31:0] === out_data[63:32]) $display("FAIL ch_differ: ch0 %h equals ch1 %h", out_data[31:0], out_data[63:32]);
        else n_pass++;
      end
      if (i < 5) commit_beat();
    end
  endtask

  task automatic test_known_seed();
    int          sel_t [3] = '{0, 1, 2};
    logic [31:0] dat_t [3] = '{32'd2, 32'd8, 32'd16};
    bit e;
    out_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seed_write(0, sel_t[i], dat_t[i], e);
      n_total++; if (seed_err !== e) $display("FAIL known_err[%0d]: got %b want %b", i, seed_err, e); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL known_flush[%0d]: got %b want 0", i, out_valid); else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL known_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_data[31:0] !== 32'h0020_2080) $display("FAIL known_beat0: got %h want 00202080", out_data[31:0]); else n_pass++;
    n_total++; if (out_data !== peek_beat()) $display("FAIL known_full0: got %h want %h", out_data, peek_beat()); else n_pass++;
    commit_beat();
    tick();
    n_total++; if (out_data[31:0] !== 32'h0200_2C80) $display("FAIL known_beat1: got %h want 02002c80", out_data[31:0]); else n_pass++;
    n_total++; if (out_data !== peek_beat()) $display("FAIL known_full1: got %h want %h", out_data, peek_beat()); else n_pass++;
  endtask

  task automatic test_seed_err();
    int          bad_ch  [6] = '{2, 7, 0, 1, 1, 0};
    int          bad_sel [6] = '{0, 1, 3, 0, 2, 1};
    logic [31:0] bad_d   [6] = '{32'd5, 32'd100, 32'd1234, 32'd1, 32'd15, 32'd0};
    logic [31:0] d;
    bit e;
    out_ready = 1'b0;
    seed_write(0, 1, 32'h7, e);
    n_total++; if (seed_err !== 1'b1) $display("FAIL err_pulse: got %b want 1", seed_err); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL err_flush: got %b want 0", out_valid); else n_pass++;
    en = 1'b0;
    tick();
    n_total++; if (seed_err !== 1'b0) $display("FAIL err_clear: got %b want 0", seed_err); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      seed_write(bad_ch[i], bad_sel[i], bad_d[i], e);
      n_total++; if (seed_err !== e) $display("FAIL err_bad[%0d]: got %b want %b", i, seed_err, e); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      d = $urandom | 32'h10;
      seed_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), d, e);
      n_total++; if (seed_err !== e) $display("FAIL err_good[%0d]: got %b want %b", i, seed_err, e); else n_pass++;
    end
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== peek_beat()) $display("FAIL err_seq[%0d]: got %h want %h", i, out_data, peek_beat()); else n_pass++;
        commit_beat();
      end
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL err_seq_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_total++; if (out_data !== peek_beat()) $display("FAIL hold_data[%0d]: got %h want %h", i, out_data, peek_beat()); else n_pass++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== peek_beat()) $display("FAIL bp_seq[%0d]: got %h want %h", i, out_data, peek_beat()); else n_pass++;
        commit_beat();
      end
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_enable();
    out_ready = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== peek_beat()) $display("FAIL en_drain: got %h want %h", out_data, peek_beat()); else n_pass++;
        commit_beat();
      end
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL en_off[%0d]: got %b want 0", i, out_valid); else n_pass++;
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== peek_beat()) $display("FAIL en_seq[%0d]: got %h want %h", i, out_data, peek_beat()); else n_pass++;
        commit_beat();
      end
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL en_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_random_stream();
    bit held;
    bit idle;
    for (int i = 0; i < 300; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      held = out_valid && !out_ready;
      idle = !out_valid && !en;
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== peek_beat()) $display("FAIL rnd_data[%0d]: got %h want %h", i, out_data, peek_beat()); else n_pass++;
        commit_beat();
      end
      tick();
      if (held) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== peek_beat()) $display("FAIL rnd_hold[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, peek_beat());
        else n_pass++;
      end
      if (idle) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL rnd_idle[%0d]: got %b want 0", i, out_valid); else n_pass++;
      end
    end
    en = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== peek_beat()) $display("FAIL mid_pre[%0d]: got %h want %h", i, out_data, peek_beat()); else n_pass++;
        commit_beat();
      end
      tick();
    end
    reset = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL mid_data: got %h want 0", out_data); else n_pass++;
    model_reset();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL rerun_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_total++; if (out_data !== first_run[i]) $display("FAIL rerun_first[%0d]: got %h want %h", i, out_data, first_run[i]); else n_pass++;
      n_total++; if (out_data !== peek_beat()) $display("FAIL rerun_model[%0d]: got %h want %h", i, out_data, peek_beat()); else n_pass++;
      commit_beat();
    end
  endtask

  initial begin
    test_reset();
    test_known_seed();
    test_seed_err();
    test_backpressure();
    test_enable();
    test_random_stream();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/taus_urng_mc.md
Name: taus_urng_mc

Overview:
- Parametrised, multi-channel successor to the single-stream Tausworthe uniform generator feeding the AWGN datapath.
- Each channel runs an independent three-component taus88 generator (s0/s1/s2, 32 b each).
- Adds runtime seed loading with validity checking, a stall-able valid/ready output stream, enable gating, and a configurable output width.
- Sits upstream of the Box-Muller / sin-cos stages; one output beat carries one sample per channel.

Parameters:
NUM_CH, 2, number of independent generator channels (1..8)
OUT_W, 32, bits emitted per channel (1..32); sample = tout[31 -: OUT_W]
SEED0, 32'h0000_1234, base default seed for component s0
SEED1, 32'h0000_5678, base default seed for component s1
SEED2, 32'h0009_ABCD, base default seed for component s2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  generator enable; 0 freezes state and output register
seed_we  in  1  seed write strobe, one word per cycle
seed_ch  in  3  target channel for seed write
seed_sel  in  2  target component: 0=s0, 1=s1, 2=s2, 3=reserved
seed_data  in  32  seed value
seed_err  out  1  one-cycle pulse: seed write rejected
out_valid  out  1  out_data holds an unconsumed beat
out_ready  in  1  downstream accepts beat
out_data  out  NUM_CH*OUT_W  channel c at [c*OUT_W +: OUT_W]

Behaviour:
- Reset (reset=0, async):
  - Channel c state: s0=(SEED0^(c*32'h9E3779B9))|32'h2, s1=(SEED1^(c*32'h9E3779B9))|32'h8, s2=(SEED2^(c*32'h9E3779B9))|32'h10.
  - out_valid=0, out_data=0, seed_err=0.
- Step function per channel, all 32-bit, shifted-out bits discarded:
  - b=((s0<<13)^s0)>>19; s0'=((s0&~1)<<12)^b
  - b=((s1<<2)^s1)>>25; s1'=((s1&~7)<<4)^b
  - b=((s2<<3)^s2)>>11; s2'=((s2&~15)<<17)^b
  - tout=s0'^s1'^s2'
- Advance condition: adv = en & ~seed_we & (~out_valid | out_ready).
- On adv, all channels step together: state<=next state, out_data<=tout slices of the new state, out_valid<=1. Latency: first beat is valid 1 cycle after the first adv cycle.
- Hold: out_valid & ~out_ready holds out_data and state stable. en=0 holds everything, but an outstanding beat may still transfer.
- A beat transfers on out_valid & out_ready. If not refilled that same cycle, out_valid<=0.
- Seed write, processed in the cycle seed_we=1:
  - Invalid if any of: seed_ch>=NUM_CH; seed_sel=3; s0 seed<2; s1 seed<8; s2 seed<16.
  - Invalid write: state unchanged, seed_err=1 next cycle.
  - Valid write: the addressed word is overwritten and the other words hold.
  - Either case: no advance; out_valid<=0, flushing the stale beat. A beat handshaken in that same cycle still counts as transferred.
  - The next adv steps from the written state.
- Back-to-back seed writes are allowed, one per cycle, with no advance between them.
- Reset mid-stream: immediate return to the reset state. Any in-flight beat is lost.
- Channels never interact; the output is identical for any out_ready pattern apart from timing.

Decomposition:
- Package taus_pkg:
  - Constants: TAUS_GOLDEN=32'h9E3779B9; minimum seeds 2/8/16; shift constants (13,19,12 / 2,25,4 / 3,11,17); component masks.
  - Seed-select enum: SEL_S0, SEL_S1, SEL_S2.
  - Function taus_step.
- Sub-module taus_core: one channel's state registers, step logic, and seed write port. Instantiated NUM_CH times by generate. The top level holds the handshake, output register and error logic.

Test Plan:
- Reset, en=1, out_ready=1, default params -> out_valid rises 1 cycle after reset release; one fresh beat per cycle thereafter; channels 0 and 1 differ.
- Write ch0 s0=2, s1=8, s2=16, then advance -> ch0 samples 32'h0020_2080 then 32'h0200_2C80.
- Write ch0 s1=32'h7 -> seed_err pulses one cycle; the following sequence matches the unseeded reference model.
- With a valid beat present, hold out_ready=0 for 5 cycles -> out_data and state stable; raise out_ready -> the next beats continue the sequence with no skip or repeat.
- Toggle en=0 mid-stream for 3 cycles -> no advance; after re-enable the sequence resumes exactly where it stopped.
- Assert reset mid-stream -> out_valid=0 and out_data=0 at once; after release the stream is identical to the first post-reset run.
